// File: rtl/udma_eth_tx_pkg.sv
// Shared types and helpers for the uDMA -> Ethernet TX framer.
package udma_eth_tx_pkg;

    // Framer states; PAD is only reachable when UDMA_ETH_TX_MIN_PAD_EN is defined.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        SEND  = 3'd2,
        FLUSH = 3'd3,
        PAD   = 3'd4
    } eth_tx_state_e;

    localparam int BYTES_PER_WORD = 4;

    // uDMA datasize code to number of valid byte lanes (code 3 behaves like 2).
    function automatic logic [2:0] lanes_from_size(input logic [1:0] datasize);
        logic [2:0] lanes;
        case (datasize)
            2'd0:    lanes = 3'd1;
            2'd1:    lanes = 3'd2;
            default: lanes = 3'(BYTES_PER_WORD);
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/udma_eth_tx_framer_if.sv
// Stream interfaces of the framer: 32-bit uDMA word input, byte-wide Ethernet output.
//
// Handshake semantics (both interfaces): a transfer happens on a rising clock
// edge where valid && ready. The master keeps valid and all payload signals
// stable until that transfer; ready may change freely and may depend
// combinationally on the master's state.

interface udma_tx_if;
    logic [31:0] data;
    logic [1:0]  datasize;
    logic        valid;
    logic        ready;

    modport master (output data, datasize, valid, input ready);
    modport slave  (input data, datasize, valid, output ready);
endinterface

interface eth_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  sof;
    logic                  eof;
    logic                  ready;

    modport master (output data, valid, sof, eof, input ready);
    modport slave  (input data, valid, sof, eof, output ready);
endinterface

// File: rtl/udma_eth_tx_unpacker.sv
// Holds the not-yet-emitted upper bytes of the current uDMA word and counts
// the lanes still to be sent. Byte 0 of a word is taken directly by the top
// at load time, so only bits [31:8] are stored here.
module udma_eth_tx_unpacker
    import udma_eth_tx_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_i,      // capture a new word (lane 0 is on the output now)
    input  logic [23:0] upper_i,     // word bits [31:8]
    input  logic [1:0]  datasize_i,
    input  logic        shift_i,     // current lane handed off downstream
    output logic [7:0]  next_byte_o, // byte that follows the one being presented
    output logic        last_lane_o  // the byte being presented is the word's last lane
);

    logic [23:0] shreg_q, shreg_d;
    logic [2:0]  lanes_q, lanes_d;

    // Next-state: load has priority, shift moves the next lane down.
    always_comb begin
        shreg_d = shreg_q;
        lanes_d = lanes_q;
        if (load_i) begin
            shreg_d = upper_i;
            lanes_d = lanes_from_size(datasize_i);
        end else if (shift_i) begin
            shreg_d = {8'h00, shreg_q[23:8]};
            lanes_d = lanes_q - 3'd1;
        end
    end

    // Shift register and lane counter state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shreg_q <= '0;
            lanes_q <= '0;
        end else begin
            shreg_q <= shreg_d;
            lanes_q <= lanes_d;
        end
    end

    assign next_byte_o = shreg_q[7:0];
    assign last_lane_o = (lanes_q == 3'd1);

endmodule

// File: rtl/udma_eth_tx_framer.sv
// uDMA TX -> Ethernet TX framer. Fetches 32-bit words from the uDMA channel,
// emits them as little-endian bytes and marks a programmed frame length with
// sof/eof. Supports aborting a frame with a single 0x00 eof byte.
//
// Optional feature: define UDMA_ETH_TX_MIN_PAD_EN to pad short frames with
// 0x00 bytes up to MIN_FRAME_BYTES.
module udma_eth_tx_framer
    import udma_eth_tx_pkg::*;
#(
    parameter int TRANS_SIZE      = 16,
    parameter int DATA_WIDTH      = 8,
    parameter int MIN_FRAME_BYTES = 60
) (
    input  logic                  sys_clk_i,
    input  logic                  rstn_i,
    input  logic                  cfg_en_i,
    input  logic                  cfg_start_i,
    input  logic                  cfg_clr_i,
    input  logic [TRANS_SIZE-1:0] cfg_frame_len_i,
    udma_tx_if.slave              udma_tx_s,
    eth_tx_if.master              eth_tx_m,
    output logic                  busy_o,
    output logic                  frame_done_o,
    output logic                  frame_abort_o,
    output eth_tx_state_e         dbg_state_o
);

    eth_tx_state_e         state_q;
    logic [TRANS_SIZE-1:0] rem_q;        // bytes of payload not yet handed off
    logic                  first_q;      // next emitted byte is the frame's first
    logic                  clr_pend_q;   // abort requested while a byte is in flight
    logic                  tx_valid_q;
    logic [7:0]            tx_data_q;
    logic                  tx_sof_q;
    logic                  tx_eof_q;
    logic                  frame_done_q;
    logic                  frame_abort_q;

    logic       udma_hs;
    logic       eth_hs;
    logic       unp_shift;
    logic [7:0] unp_next_byte;
    logic       unp_last_lane;
    logic       eof_on_load;   // byte 0 of the word being accepted closes the frame
    logic       eof_on_shift;  // the byte after the current one closes the frame

`ifdef UDMA_ETH_TX_MIN_PAD_EN
    logic [TRANS_SIZE-1:0] emitted_q;    // bytes handed off in this frame
    logic                  min_ok_cur;   // frame long enough once the current byte is out
    logic                  min_ok_next;  // frame long enough once the next byte is out

    assign min_ok_cur   = (32'(emitted_q) + 32'd1) >= 32'(MIN_FRAME_BYTES);
    assign min_ok_next  = (32'(emitted_q) + 32'd2) >= 32'(MIN_FRAME_BYTES);
    assign eof_on_load  = (rem_q == TRANS_SIZE'(1)) && min_ok_cur;
    assign eof_on_shift = (rem_q == TRANS_SIZE'(2)) && min_ok_next;
`else
    localparam int min_frame_unused = MIN_FRAME_BYTES;
    assign eof_on_load  = (rem_q == TRANS_SIZE'(1));
    assign eof_on_shift = (rem_q == TRANS_SIZE'(2));
`endif

    // Words are only taken in FETCH; an abort in the same cycle wins so no word is lost.
    assign udma_tx_s.ready = (state_q == FETCH) && !cfg_clr_i;
    assign udma_hs         = udma_tx_s.ready && udma_tx_s.valid;
    assign eth_hs          = tx_valid_q && eth_tx_m.ready;
    assign unp_shift       = eth_hs && (state_q == SEND);

    udma_eth_tx_unpacker u_unpacker (
        .clk_i       (sys_clk_i),
        .rst_ni      (rstn_i),
        .load_i      (udma_hs),
        .upper_i     (udma_tx_s.data[31:8]),
        .datasize_i  (udma_tx_s.datasize),
        .shift_i     (unp_shift),
        .next_byte_o (unp_next_byte),
        .last_lane_o (unp_last_lane)
    );

    // Frame FSM with registered stream outputs and status pulses.
    always_ff @(posedge sys_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q       <= IDLE;
            rem_q         <= '0;
            first_q       <= 1'b0;
            clr_pend_q    <= 1'b0;
            tx_valid_q    <= 1'b0;
            tx_data_q     <= '0;
            tx_sof_q      <= 1'b0;
            tx_eof_q      <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_abort_q <= 1'b0;
`ifdef UDMA_ETH_TX_MIN_PAD_EN
            emitted_q     <= '0;
`endif
        end else begin
            frame_done_q  <= 1'b0;
            frame_abort_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cfg_start_i && cfg_en_i && (cfg_frame_len_i != '0)) begin
                        state_q    <= FETCH;
                        rem_q      <= cfg_frame_len_i;
                        first_q    <= 1'b1;
                        clr_pend_q <= 1'b0;
`ifdef UDMA_ETH_TX_MIN_PAD_EN
                        emitted_q  <= '0;
`endif
                    end
                end
                FETCH: begin
                    if (cfg_clr_i) begin
                        state_q    <= FLUSH;
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= 8'h00;
                        tx_sof_q   <= first_q;
                        tx_eof_q   <= 1'b1;
                    end else if (udma_hs) begin
                        state_q    <= SEND;
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= udma_tx_s.data[7:0];
                        tx_sof_q   <= first_q;
                        tx_eof_q   <= eof_on_load;
                    end
                end
                SEND: begin
                    if (eth_hs) begin
                        rem_q      <= rem_q - TRANS_SIZE'(1);
                        first_q    <= 1'b0;
                        clr_pend_q <= 1'b0;
                        tx_sof_q   <= 1'b0;
`ifdef UDMA_ETH_TX_MIN_PAD_EN
                        emitted_q  <= emitted_q + TRANS_SIZE'(1);
`endif
                        if (tx_eof_q) begin
                            state_q      <= IDLE;
                            tx_valid_q   <= 1'b0;
                            tx_eof_q     <= 1'b0;
                            frame_done_q <= 1'b1;
                        end else if (clr_pend_q || cfg_clr_i) begin
                            state_q   <= FLUSH;
                            tx_data_q <= 8'h00;
                            tx_eof_q  <= 1'b1;
`ifdef UDMA_ETH_TX_MIN_PAD_EN
                        end else if (rem_q == TRANS_SIZE'(1)) begin
                            state_q   <= PAD;
                            tx_data_q <= 8'h00;
                            tx_eof_q  <= min_ok_next;
`endif
                        end else if (unp_last_lane) begin
                            state_q    <= FETCH;
                            tx_valid_q <= 1'b0;
                        end else begin
                            tx_data_q <= unp_next_byte;
                            tx_eof_q  <= eof_on_shift;
                        end
                    end else if (cfg_clr_i) begin
                        clr_pend_q <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (eth_hs) begin
                        state_q       <= IDLE;
                        tx_valid_q    <= 1'b0;
                        tx_sof_q      <= 1'b0;
                        tx_eof_q      <= 1'b0;
                        first_q       <= 1'b0;
                        clr_pend_q    <= 1'b0;
                        frame_abort_q <= 1'b1;
                    end
                end
`ifdef UDMA_ETH_TX_MIN_PAD_EN
                PAD: begin
                    if (eth_hs) begin
                        emitted_q  <= emitted_q + TRANS_SIZE'(1);
                        clr_pend_q <= 1'b0;
                        if (tx_eof_q) begin
                            state_q      <= IDLE;
                            tx_valid_q   <= 1'b0;
                            tx_eof_q     <= 1'b0;
                            frame_done_q <= 1'b1;
                        end else if (clr_pend_q || cfg_clr_i) begin
                            state_q  <= FLUSH;
                            tx_eof_q <= 1'b1;
                        end else begin
                            tx_eof_q <= min_ok_next;
                        end
                    end else if (cfg_clr_i) begin
                        clr_pend_q <= 1'b1;
                    end
                end
`endif
                default: begin
                    state_q    <= IDLE;
                    tx_valid_q <= 1'b0;
                    tx_sof_q   <= 1'b0;
                    tx_eof_q   <= 1'b0;
                end
            endcase
        end
    end

    // Eth-side data is a byte zero-extended to DATA_WIDTH.
    always_comb begin
        eth_tx_m.data      = '0;
        eth_tx_m.data[7:0] = tx_data_q;
    end

    assign eth_tx_m.valid = tx_valid_q;
    assign eth_tx_m.sof   = tx_sof_q;
    assign eth_tx_m.eof   = tx_eof_q;
    assign busy_o         = (state_q != IDLE);
    assign frame_done_o   = frame_done_q;
    assign frame_abort_o  = frame_abort_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_udma_eth_tx_framer.sv
// Bench for udma_eth_tx_framer: directed and randomized frames checked
// against a byte-stream model built from the framing rules.
module tb_udma_eth_tx_framer;
    import udma_eth_tx_pkg::*;

    localparam int DW   = 8;
    localparam int MINB = 60;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          cfg_en = 1'b0;
    logic          cfg_start = 1'b0;
    logic          cfg_clr = 1'b0;
    logic [15:0]   cfg_len = '0;
    logic          busy, done, abort;
    eth_tx_state_e dbg;

    udma_tx_if              u_if ();
    eth_tx_if #(.DATA_WIDTH(DW)) e_if ();

    udma_eth_tx_framer #(.TRANS_SIZE(16), .DATA_WIDTH(DW), .MIN_FRAME_BYTES(MINB)) dut (
        .sys_clk_i       (clk),
        .rstn_i          (rstn),
        .cfg_en_i        (cfg_en),
        .cfg_start_i     (cfg_start),
        .cfg_clr_i       (cfg_clr),
        .cfg_frame_len_i (cfg_len),
        .udma_tx_s       (u_if),
        .eth_tx_m        (e_if),
        .busy_o          (busy),
        .frame_done_o    (done),
        .frame_abort_o   (abort),
        .dbg_state_o     (dbg)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [31:0] word_q[$];
    logic [9:0]  exp_q[$];   // {sof, eof, data}
    logic [9:0]  obs_q[$];
    int bubbles, rdy_cnt, done_cnt, abort_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int lanes_of(input int ds);
        return (ds == 0) ? 1 : (ds == 1) ? 2 : 4;
    endfunction

    task automatic fill_words(input int len, input int ds);
        int n;
        n = (len + lanes_of(ds) - 1) / lanes_of(ds);
        word_q.delete();
        for (int i = 0; i < n; i++) word_q.push_back($urandom);
    endtask

    // Expected byte stream: payload bytes in little-endian lane order, cut at len
    // (or after byte abort_k followed by a 0x00 abort byte), optionally padded.
    function automatic void build_exp(input int len, input int ds, input int abort_k);
        logic [7:0] payload[$];
        logic [7:0] d[$];
        logic [31:0] w;
        foreach (word_q[i]) begin
            w = word_q[i];
            for (int l = 0; l < lanes_of(ds); l++)
                if (payload.size() < len) payload.push_back(8'(w >> (8 * l)));
        end
        if (abort_k >= 0 && abort_k < len - 1) begin
            for (int i = 0; i <= abort_k; i++) d.push_back(payload[i]);
            d.push_back(8'h00);
        end else begin
            for (int i = 0; i < len; i++) d.push_back(payload[i]);
`ifdef UDMA_ETH_TX_MIN_PAD_EN
            while (d.size() < MINB) d.push_back(8'h00);
`endif
        end
        exp_q.delete();
        foreach (d[i]) exp_q.push_back({(i == 0), (i == d.size() - 1), d[i]});
    endfunction

    // Run one frame cycle by cycle: inputs set on the falling edge, outputs
    // sampled 1ns later, transfers happen on the following rising edge.
    task automatic run_frame(input string name, input int len, input int ds, input int rdy_pct,
                             input int vld_pct, input int abort_k, input int busy_start_at);
        int widx, cyc, drain;
        bit seen_eof, stall_prev, clr_sent, aborting;
        logic [10:0] prev;
        build_exp(len, ds, abort_k);
        aborting = (abort_k >= 0 && abort_k < len - 1);
        obs_q.delete();
        bubbles = 0; rdy_cnt = 0; done_cnt = 0; abort_cnt = 0;
        widx = 0; cyc = 0; drain = 0; seen_eof = 0; stall_prev = 0; clr_sent = 0; prev = '0;
        @(negedge clk);
        cfg_en = 1'b1; cfg_start = 1'b1; cfg_len = 16'(len);
        @(negedge clk);
        cfg_start = 1'b0;
        while (drain < 3 && cyc < 3000) begin
            e_if.ready    = ($urandom_range(99) < rdy_pct);
            u_if.valid    = (widx < word_q.size()) && ($urandom_range(99) < vld_pct);
            u_if.data     = (widx < word_q.size()) ? word_q[widx] : $urandom;
            u_if.datasize = 2'(ds);
            cfg_clr       = 1'b0;
            cfg_start     = 1'b0;
            if (aborting && !clr_sent && e_if.valid && obs_q.size() == abort_k) begin
                cfg_clr = 1'b1; e_if.ready = 1'b1; clr_sent = 1'b1;
            end
            if (cyc == busy_start_at) begin cfg_start = 1'b1; cfg_len = 16'd3; end
            if (cyc == busy_start_at + 1) cfg_en = 1'b0;
            #1;
            if (stall_prev)
                check({name, "_stall_stable"}, 32'({e_if.valid, e_if.sof, e_if.eof, e_if.data}), 32'(prev));
            stall_prev = e_if.valid && !e_if.ready;
            prev = {e_if.valid, e_if.sof, e_if.eof, e_if.data};
            if (e_if.valid && e_if.ready) begin
                obs_q.push_back({e_if.sof, e_if.eof, e_if.data});
                if (e_if.eof) seen_eof = 1'b1;
            end
            if (!seen_eof && busy && !e_if.valid) bubbles++;
            if (u_if.ready) rdy_cnt++;
            if (u_if.ready && u_if.valid) widx++;
            if (done) done_cnt++;
            if (abort) abort_cnt++;
            if (seen_eof) drain++;
            cyc++;
            @(negedge clk);
        end
        cfg_en = 1'b1; cfg_clr = 1'b0; cfg_start = 1'b0; u_if.valid = 1'b0;
        check({name, "_eof_seen"}, 32'(seen_eof), 32'd1);
        check({name, "_byte_count"}, obs_q.size(), exp_q.size());
        foreach (exp_q[i])
            if (i < obs_q.size()) check({name, "_byte"}, 32'(obs_q[i]), 32'(exp_q[i]));
        check({name, "_done_pulses"}, done_cnt, aborting ? 0 : 1);
        check({name, "_abort_pulses"}, abort_cnt, aborting ? 1 : 0);
        check({name, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int len, ds, ak;
        u_if.valid = 1'b0; u_if.data = '0; u_if.datasize = '0; e_if.ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({e_if.valid, e_if.sof, e_if.eof, e_if.data, busy, done, abort, u_if.ready}), 32'd0);
        check("reset_state", 32'(dbg), 32'(IDLE));
        rstn = 1'b1;
        @(negedge clk);

        // Ignored starts and idle clear
        cfg_en = 1'b1; cfg_len = 16'd0; cfg_start = 1'b1;
        @(negedge clk); cfg_start = 1'b0; @(negedge clk);
        check("start_len0_ignored", 32'(busy), 32'd0);
        cfg_en = 1'b0; cfg_len = 16'd5; cfg_start = 1'b1;
        @(negedge clk); cfg_start = 1'b0; @(negedge clk);
        check("start_dis_ignored", 32'(busy), 32'd0);
        cfg_clr = 1'b1; @(negedge clk); cfg_clr = 1'b0; @(negedge clk);
        check("clr_idle_noeffect", 32'({busy, e_if.valid, abort}), 32'd0);

        // Directed: two full words
        word_q = '{32'h44332211, 32'h88776655};
        run_frame("len8_ds2", 8, 2, 100, 100, -1, -1);
        check("len8_bubbles", bubbles, 2);
        check("len8_udma_ready", rdy_cnt, 2);

        // Directed: partial last word, upper lanes dropped
        word_q = '{32'hDDCCBBAA, 32'h00000EEE};
        run_frame("len5_ds2", 5, 2, 100, 100, -1, -1);

        // Directed: single-byte words
        fill_words(3, 0);
        run_frame("len3_ds0", 3, 0, 100, 100, -1, -1);
        check("len3_udma_ready", rdy_cnt, 3);
        check("len3_bubbles", bubbles, 3);

        // Random stalls, len 64, start/enable toggled mid-frame
        ds = $urandom_range(3);
        fill_words(64, ds);
        run_frame("len64_stall", 64, ds, 50, 70, -1, 6);

        // Abort while byte 2 is in SEND
        fill_words(10, 2);
        run_frame("abort_b2", 10, 2, 100, 100, 2, -1);

        // Random frames, some aborted
        for (int i = 0; i < 6; i++) begin
            len = $urandom_range(20, 1);
            ds  = $urandom_range(3);
            ak  = (len > 1 && $urandom_range(1) == 1) ? $urandom_range(len - 2) : -1;
            fill_words(len, ds);
            run_frame("rand", len, ds, 70, 80, ak, -1);
        end

`ifdef UDMA_ETH_TX_MIN_PAD_EN
        fill_words(14, 2);
        run_frame("pad_len14", 14, 2, 100, 100, -1, -1);
`endif

        // Asynchronous reset in the middle of a frame
        @(negedge clk);
        cfg_en = 1'b1; cfg_len = 16'd20; cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0; u_if.valid = 1'b1; u_if.datasize = 2'd2; u_if.data = $urandom; e_if.ready = 1'b1;
        repeat (4) @(negedge clk);
        check("midframe_valid", 32'(e_if.valid), 32'd1);
        #2 rstn = 1'b0;
        #1;
        check("async_rst_outputs", 32'({e_if.valid, e_if.sof, e_if.eof, busy, done, abort}), 32'd0);
        check("async_rst_state", 32'(dbg), 32'(IDLE));
        u_if.valid = 1'b0;
        @(negedge clk); rstn = 1'b1;

        fill_words(6, 1);
        run_frame("after_reset", 6, 1, 80, 90, -1, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
